// File: rtl/cpu_run_ctrl.sv
// rtl/cpu_run_ctrl.sv - CPU run controller: clock-enable divider, reset sequencing, single-step, cycle count, watchdog
module cpu_run_ctrl #(
  parameter int DIV_WIDTH  = 8,
  parameter int CYC_WIDTH  = 24,
  parameter int RST_CYCLES = 4
) (
  input  logic                 clock,
  input  logic                 resetn,
  input  logic                 start,
  input  logic                 step_mode,
  input  logic                 step,
  input  logic [DIV_WIDTH-1:0] div_ratio,
  input  logic [CYC_WIDTH-1:0] timeout_limit,
  input  logic                 cpu_done,
  output logic                 cpu_en,
  output logic                 cpu_rst,
  output logic                 busy,
  output logic                 finished,
  output logic                 timed_out,
  output logic [CYC_WIDTH-1:0] cycles
);

  // Reset-hold counter only needs to reach RST_CYCLES-1.
  localparam int RCW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [RCW-1:0] RST_LAST = RCW'(RST_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RST  = 3'd1,
    ST_RUN  = 3'd2,
    ST_DONE = 3'd3,
    ST_TOUT = 3'd4
  } state_e;

  state_e               state_q, state_d;
  logic [DIV_WIDTH-1:0] div_cnt_q, div_cnt_d;
  logic [RCW-1:0]       rst_cnt_q, rst_cnt_d;
  logic [CYC_WIDTH-1:0] cycles_q, cycles_d;
  logic                 start_q, step_q;
  logic                 cpu_en_q, cpu_en_d;
  logic                 cpu_rst_q, cpu_rst_d;
  logic                 busy_q, busy_d;
  logic                 finished_q, finished_d;
  logic                 timed_out_q, timed_out_d;

  logic start_edge;
  logic step_edge;
  logic wdog_hit;

  assign start_edge = start & ~start_q;
  assign step_edge  = step & ~step_q;
  // cycles_q already counts the pulse issued on the previous clock, so equality
  // here stops the run before any pulse beyond the limit.
  assign wdog_hit   = (timeout_limit != '0) && (cycles_q == timeout_limit);

  // Next-state, divider, reset-hold and cycle-count logic.
  always_comb begin
    state_d   = state_q;
    div_cnt_d = div_cnt_q;
    rst_cnt_d = rst_cnt_q;
    cycles_d  = cycles_q;
    cpu_en_d  = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE, ST_TOUT: begin
        if (start_edge) begin
          state_d   = ST_RST;
          div_cnt_d = '0;
          rst_cnt_d = '0;
          cycles_d  = '0;
        end
      end

      ST_RST: begin
        if (rst_cnt_q == RST_LAST) begin
          state_d = ST_RUN;
        end else begin
          rst_cnt_d = rst_cnt_q + RCW'(1);
        end
      end

      ST_RUN: begin
        if (cpu_done) begin
          // Done has priority over the watchdog and suppresses any pulse.
          state_d = ST_DONE;
        end else if (wdog_hit) begin
          state_d = ST_TOUT;
        end else if (step_mode) begin
          // Divider frozen; only step edges advance the CPU.
          cpu_en_d = step_edge;
        end else if (div_cnt_q == div_ratio) begin
          cpu_en_d  = 1'b1;
          div_cnt_d = '0;
        end else if (div_cnt_q > div_ratio) begin
          // Ratio shrank below the running count: wrap silently.
          div_cnt_d = '0;
        end else begin
          div_cnt_d = div_cnt_q + DIV_WIDTH'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Count issued pulses, saturating at all-ones.
    if (cpu_en_d && (cycles_q != '1)) begin
      cycles_d = cycles_q + CYC_WIDTH'(1);
    end
  end

  // Status outputs follow the next state so they are registered alongside it.
  always_comb begin
    cpu_rst_d   = (state_d == ST_RST);
    busy_d      = (state_d == ST_RST) || (state_d == ST_RUN);
    finished_d  = (state_d == ST_DONE) || (state_d == ST_TOUT);
    timed_out_d = (state_d == ST_TOUT);
  end

  // State and datapath registers.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q   <= ST_IDLE;
      div_cnt_q <= '0;
      rst_cnt_q <= '0;
      cycles_q  <= '0;
    end else begin
      state_q   <= state_d;
      div_cnt_q <= div_cnt_d;
      rst_cnt_q <= rst_cnt_d;
      cycles_q  <= cycles_d;
    end
  end

  // Edge-detect history for start and step.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      start_q <= 1'b0;
      step_q  <= 1'b0;
    end else begin
      start_q <= start;
      step_q  <= step;
    end
  end

  // Registered control and status outputs.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      cpu_en_q    <= 1'b0;
      cpu_rst_q   <= 1'b0;
      busy_q      <= 1'b0;
      finished_q  <= 1'b0;
      timed_out_q <= 1'b0;
    end else begin
      cpu_en_q    <= cpu_en_d;
      cpu_rst_q   <= cpu_rst_d;
      busy_q      <= busy_d;
      finished_q  <= finished_d;
      timed_out_q <= timed_out_d;
    end
  end

  assign cpu_en    = cpu_en_q;
  assign cpu_rst   = cpu_rst_q;
  assign busy      = busy_q;
  assign finished  = finished_q;
  assign timed_out = timed_out_q;
  assign cycles    = cycles_q;

endmodule

// File: doc/cpu_run_ctrl.md
Name: cpu_run_ctrl

Overview:
Run controller that sits between the board-level top and the CPU core. It is the parametrised successor of the fixed clock-divider/start/finished scheme. It generates a single-cycle clock-enable for the CPU (no derived clocks) at a programmable divide ratio, and holds the CPU in reset for a fixed number of cycles before each run. It adds single-step mode, a run-length cycle counter and a timeout watchdog, and drives the finished/busy status.

Parameters:
DIV_WIDTH, 8, width of the div_ratio input and the internal divider counter
CYC_WIDTH, 24, width of the executed-cycle counter and the timeout_limit input
RST_CYCLES, 4, number of clock cycles cpu_rst is held high at the start of each run (at least 1)

Ports:
clock  input  1  system clock; every flop is on its rising edge
resetn  input  1  asynchronous active-low reset
start  input  1  level input; a run begins on its rising edge (edge detected internally)
step_mode  input  1  1 = single-step; 0 = free-run at the divided rate
step  input  1  level input; each rising edge in step mode grants exactly one cpu_en pulse
div_ratio  input  DIV_WIDTH  cpu_en period in free-run is div_ratio+1 clocks
timeout_limit  input  CYC_WIDTH  watchdog limit in cpu_en pulses; 0 disables the watchdog
cpu_done  input  1  CPU halt indication, level
cpu_en  output  1  one-clock enable pulse that advances the CPU by one step
cpu_rst  output  1  synchronous reset to the CPU, active high
busy  output  1  high in RST and RUN
finished  output  1  high in DONE and TOUT
timed_out  output  1  high in TOUT only
cycles  output  CYC_WIDTH  number of cpu_en pulses issued in the current or last run

Behaviour:
- Reset (resetn=0, async):
  - state=IDLE.
  - cpu_en=0, cpu_rst=0, busy=0, finished=0, timed_out=0, cycles=0.
  - Divider counter = 0; start and step edge registers = 0.
- All outputs are registered.
- Edge detection: one register each on start and step. An edge is seen when the current input is 1 and the registered value is 0. An edge present at reset release is detected on the first clock.
- States are IDLE, RST, RUN, DONE, TOUT.
- IDLE, on a start edge, goes to RST:
  - cycles cleared to 0, divider counter cleared to 0.
  - cpu_rst=1 from the next cycle.
- RST:
  - Holds cpu_rst=1 for exactly RST_CYCLES clocks, then goes to RUN with cpu_rst=0.
  - cpu_en=0 throughout RST.
- RUN, free-run (step_mode=0):
  - Divider counts 0..div_ratio.
  - cpu_en=1 for one clock each time the counter equals div_ratio; the counter then wraps to 0.
  - First cpu_en pulse comes div_ratio+1 clocks after RUN entry.
  - div_ratio=0 gives cpu_en high every clock.
  - A change to div_ratio mid-run takes effect at the next compare. If the counter already exceeds the new value, it wraps to 0 without a pulse.
- RUN, step mode (step_mode=1):
  - Divider frozen; no free-run pulses.
  - Each step edge produces cpu_en=1 on the following clock only.
  - Step edges outside RUN are ignored and not queued.
- Mode switch mid-run:
  - step_mode 1->0 resumes the divider from its frozen value.
  - step_mode 0->1 freezes the divider immediately.
- cycles:
  - Increments by 1 on every clock where cpu_en=1.
  - Saturates at all-ones.
  - Holds its value through DONE/TOUT until the next start edge.
- Completion:
  - cpu_done=1 sampled in RUN means next state DONE.
  - cpu_en is forced 0 in the clock where cpu_done is sampled, so no pulse is issued after done.
  - cpu_done is ignored in IDLE and RST.
- Watchdog:
  - When timeout_limit!=0 and cycles==timeout_limit in RUN, the next state is TOUT; no further cpu_en.
  - If cpu_done and the watchdog condition are true in the same clock, DONE wins and timed_out stays 0.
- DONE/TOUT:
  - finished=1 (and timed_out=1 in TOUT) until the next start edge.
  - A start edge re-enters RST (restart) and clears finished, timed_out and cycles.
- Start edges during RST or RUN are ignored; there is no abort.
- Asserting resetn mid-run forces IDLE immediately. cpu_rst goes 0, so the CPU is not reset by the controller; the top must reset the CPU separately.

Test Plan:
- Reset/idle: resetn low for 3 clocks then high, no start -> all outputs 0 and cycles=0 for 20 clocks.
- Free-run divide: div_ratio=3, start edge -> cpu_rst high exactly 4 clocks; cpu_en pulses every 4th clock; cpu_done raised after the 10th pulse -> cycles=10, finished=1, busy=0, no 11th pulse.
- div_ratio=0 and mid-run change:
  - div_ratio=0 -> cpu_en continuous in RUN.
  - Switch to div_ratio=2 mid-run -> period becomes 3 clocks with no extra or missed pulse beyond the one wrap.
- Single-step: step_mode=1, 5 step edges spaced irregularly, plus one step held high for 10 clocks -> exactly 6 cpu_en pulses, each one clock wide, cycles=6.
- Watchdog:
  - timeout_limit=7, cpu_done never asserted -> TOUT after the 7th pulse; timed_out=1, finished=1, cycles=7.
  - Repeat with cpu_done asserted in the same clock cycles hits 7 -> DONE, timed_out=0.
- Restart and async reset:
  - Start edge in DONE -> finished clears, cycles=0, RST sequence repeats.
  - resetn pulsed low mid-RUN between clock edges -> outputs go to reset values immediately, without waiting for a clock edge.
